hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage core. It reads the register addresses and control bits carried by the decode→execute and later pipeline registers and drives three things: the forwarding selects for the execute-stage ALU operands, and the stall and flush enables for every pipeline register. It also runs a small state machine that freezes the pipeline while data memory is busy. Saturating counters record stall and flush events for performance analysis.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/forward_sel.sv | 18 +
 rtl/hazard_unit.sv | 101 ++++++++++
 tb/tb_hazard_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
    typedef enum logic {RUN, MEM_WAIT} hz_state_t;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/forward_sel.sv
// forward_sel: picks the bypass source for one execute-stage ALU operand.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] RsE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    output fwd_sel_t              fwd
);
    // The memory stage holds the younger result, so it wins over writeback.
    always_comb
        fwd = (RegWriteM && RdM != '0 && RdM == RsE) ? FWD_MEM :
              (RegWriteW && RdW != '0 && RdW == RsE) ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, stall/flush enables, memory-wait FSM and
// saturating stall/flush event counters for the five-stage core.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemErr,
    output logic [CNT_W-1:0]      StallCnt,
    output logic [CNT_W-1:0]      FlushCnt
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;

    fwd_sel_t       fwd_a, fwd_b;
    hz_state_t      state, state_nx;
    logic [WW-1:0]  wait_cnt;
    logic           lw_stall, mem_stall, waiting, timeout;

    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .RsE(Rs1E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_a)
    );
    forward_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .RsE(Rs2E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_b)
    );

    assign lw_stall  = ResultSrcE == RESULT_SRC_LOAD && RdE != '0 && (Rs1D == RdE || Rs2D == RdE);
    assign mem_stall = MemReqM && !MemReadyM;

    // A busy data memory freezes the whole pipe and masks load-use and branch effects.
    always_comb begin
        ForwardAE = rst_n ? fwd_a : FWD_RF;
        ForwardBE = rst_n ? fwd_b : FWD_RF;
        StallF    = rst_n && (mem_stall || (lw_stall && !PCSrcE));
        StallD    = StallF;
        StallE    = rst_n && mem_stall;
        StallM    = StallE;
        FlushD    = !rst_n || (!mem_stall && PCSrcE);
        FlushE    = !rst_n || (!mem_stall && (lw_stall || PCSrcE));
        FlushW    = !rst_n || mem_stall;
    end

    always_ff @(posedge clk)
        state <= !rst_n ? RUN : state_nx;

    always_comb
        state_nx = (state == RUN) ? (mem_stall ? MEM_WAIT : RUN) : (MemReadyM ? RUN : MEM_WAIT);

    always_comb begin
        waiting = state == MEM_WAIT;
        timeout = waiting && wait_cnt == WW'(MEM_TIMEOUT - 1);
    end

    // wait_cnt sits at zero in RUN, so it is clear on entry; it parks at the timeout value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            MemErr   <= 1'b0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (!waiting)
                wait_cnt <= '0;
            else if (!timeout)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout)
                MemErr <= 1'b1;
            if (StallF && !(&StallCnt))
                StallCnt <= StallCnt + 1'b1;
            if (FlushD && !(&FlushCnt))
                FlushCnt <= FlushCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against a rule-level model,
// using a default instance and a small one (CNT_W=2, MEM_TIMEOUT=4).
module tb_hazard_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE, ForwardAE2, ForwardBE2;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
    logic       StallF2, StallD2, StallE2, StallM2, FlushD2, FlushE2, FlushW2, MemErr2;
    logic [15:0] StallCnt, FlushCnt;
    logic [1:0]  StallCnt2, FlushCnt2;

    int passed = 0, total = 0;
    int sc = 0, fc = 0, sc2 = 0, fc2 = 0;
    bit w1 = 0, w2 = 0, e1 = 0, e2 = 0;
    int n1 = 0, n2 = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_unit #(.CNT_W(2), .MEM_TIMEOUT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2), .StallF(StallF2), .StallD(StallD2),
        .StallE(StallE2), .StallM(StallM2), .FlushD(FlushD2), .FlushE(FlushE2), .FlushW(FlushW2),
        .MemErr(MemErr2), .StallCnt(StallCnt2), .FlushCnt(FlushCnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // A wait lasts from the entry edge until ready; the error appears once T wait cycles have elapsed.
    task automatic wait_model(inout bit w, inout int n, inout bit e, input int t, input bit ms);
        if (w) begin
            n++;
            if (n >= t) e = 1;
            if (MemReadyM) w = 0;
        end else if (ms) begin
            w = 1;
            n = 0;
        end
    endtask

    task automatic step();
        bit ms, lw, sf, se, fd, fe, fw;
        logic [1:0] fa, fb;
        ms = MemReqM && !MemReadyM;
        lw = ResultSrcE == 2'b01 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        if (!rst_n) begin
            fa = 0; fb = 0; sf = 0; se = 0; fd = 1; fe = 1; fw = 1;
        end else begin
            fa = fwd_exp(Rs1E);
            fb = fwd_exp(Rs2E);
            sf = ms ? 1 : (lw && !PCSrcE);
            se = ms;
            fd = ms ? 0 : PCSrcE;
            fe = ms ? 0 : (lw || PCSrcE);
            fw = ms;
        end
        #1;
        chk("ForwardAE", ForwardAE, fa);
        chk("ForwardBE", ForwardBE, fb);
        chk("StallF", StallF, sf);
        chk("StallD", StallD, sf);
        chk("StallE", StallE, se);
        chk("StallM", StallM, se);
        chk("FlushD", FlushD, fd);
        chk("FlushE", FlushE, fe);
        chk("FlushW", FlushW, fw);
        chk("StallF_small", StallF2, sf);
        chk("MemErr", MemErr, e1);
        chk("StallCnt", StallCnt, sc);
        chk("FlushCnt", FlushCnt, fc);
        chk("MemErr_small", MemErr2, e2);
        chk("StallCnt_small", StallCnt2, sc2);
        chk("FlushCnt_small", FlushCnt2, fc2);
        chk("state_wait", dut.state == MEM_WAIT, w1);
        @(posedge clk);
        if (!rst_n) begin
            sc = 0; fc = 0; sc2 = 0; fc2 = 0;
            w1 = 0; w2 = 0; n1 = 0; n2 = 0; e1 = 0; e2 = 0;
        end else begin
            sc  = (sf && sc  < 65535) ? sc + 1  : sc;
            fc  = (fd && fc  < 65535) ? fc + 1  : fc;
            sc2 = (sf && sc2 < 3)     ? sc2 + 1 : sc2;
            fc2 = (fd && fc2 < 3)     ? fc2 + 1 : fc2;
            wait_model(w1, n1, e1, 64, ms);
            wait_model(w2, n2, e2, 4, ms);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        idle();
        rst_n = 0;
        Rs1E = 5; RdM = 5; RegWriteM = 1; PCSrcE = 1;
        @(negedge clk);
        step();
        step();
        rst_n = 1;
        idle();
        // forwarding priority
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        step();
        RdM = 0;
        step();
        Rs2E = 5; RdW = 0;
        step();
        idle();
        // load-use, then branch during load-use
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        step();
        ResultSrcE = 0;
        step();
        ResultSrcE = 2'b01; PCSrcE = 1;
        step();
        idle();
        step();
        // memory wait then release
        MemReqM = 1;
        repeat (3) step();
        MemReadyM = 1;
        step();
        idle();
        step();
        // timeout on the small instance
        MemReqM = 1;
        repeat (10) step();
        MemReadyM = 1;
        step();
        idle();
        step();
        chk("MemErr_sticky", MemErr2, 1);
        // counter saturation
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        repeat (5) step();
        chk("StallCnt_sat", StallCnt2, 3);
        idle();
        // reset in the middle of a wait
        MemReqM = 1;
        repeat (2) step();
        rst_n = 0;
        step();
        rst_n = 1;
        idle();
        step();
        chk("MemErr_cleared", MemErr2, 0);
        // ready rising together with a taken branch
        MemReqM = 1;
        step();
        MemReadyM = 1; PCSrcE = 1;
        step();
        idle();
        step();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom % 64) != 0;
            Rs1D       = 5'($urandom % 4);
            Rs2D       = 5'($urandom % 4);
            Rs1E       = 5'($urandom % 4);
            Rs2E       = 5'($urandom % 4);
            RdE        = 5'($urandom % 4);
            RdM        = 5'($urandom % 4);
            RdW        = 5'($urandom % 4);
            ResultSrcE = 2'($urandom % 4);
            PCSrcE     = ($urandom % 4) == 0;
            RegWriteM  = $urandom % 2;
            RegWriteW  = $urandom % 2;
            MemReqM    = ($urandom % 3) == 0;
            MemReadyM  = ($urandom % 3) == 0;
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
